// File: rtl/cmos_pixel_pack.sv
// cmos_pixel_pack
//   Packs an 8-bit CMOS camera byte stream (RGB565, high byte first) into
//   16-bit pixels with column/line coordinates. Discards SKIP_FRAMES whole
//   frames after reset so the sensor can settle before any output is shown.
//
// Ports
//   clk        camera pixel clock, all logic on the rising edge
//   rst        asynchronous active-low reset
//   cam_vsync  frame sync (active high), rising edge marks a frame start
//   cam_href   line valid (active high)
//   cam_data   camera byte
//   pix_data   packed pixel {first byte, second byte}, held between strobes
//   pix_de     one-cycle strobe per packed pixel
//   pix_vs     frame sync, aligned with pix_de (2-cycle latency)
//   pix_x      column of the current pixel, valid with pix_de
//   pix_y      line of the current pixel, valid with pix_de
//   line_err   one-cycle pulse after a line with odd bytes or != H_ACT pixels
module cmos_pixel_pack #(
    parameter int SKIP_FRAMES = 10,
    parameter int H_ACT       = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [15:0] pix_data,
    output logic        pix_de,
    output logic        pix_vs,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        line_err
);

    localparam int          FCW     = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);
    localparam logic [FCW-1:0] FC_MAX = FCW'(SKIP_FRAMES);
    localparam logic [10:0] XY_MAX  = 11'd2047;
    localparam logic [10:0] H_ACT_V = 11'(H_ACT);

    // S1 input stage and its one-cycle history
    logic           s1_vs, s1_hr, s1_vs_d, s1_hr_d;
    logic [7:0]     s1_data;
    // Set once a genuine low vsync has been sampled since reset, so a
    // release in the middle of a high vsync cannot look like a rising edge.
    logic           vs_armed;

    logic           byte_phase;
    logic [7:0]     hi_byte;
    logic [FCW-1:0] frame_cnt;
    logic           gate;
    logic [10:0]    xcnt, ycnt;

    logic frame_start, line_end, emit, gate_nxt, bad_line;

    always_comb begin
        frame_start = s1_vs & ~s1_vs_d & vs_armed;
        line_end    = s1_hr_d & ~s1_hr;
        emit        = s1_hr & byte_phase;
        gate_nxt    = gate | (frame_start & (frame_cnt == FC_MAX));
        // byte_phase still holds the parity of the finished line here
        bad_line    = byte_phase | (xcnt != H_ACT_V);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vs      <= 1'b0;
            s1_hr      <= 1'b0;
            s1_vs_d    <= 1'b0;
            s1_hr_d    <= 1'b0;
            s1_data    <= '0;
            vs_armed   <= 1'b0;
            byte_phase <= 1'b0;
            hi_byte    <= '0;
            frame_cnt  <= '0;
            gate       <= 1'b0;
            xcnt       <= '0;
            ycnt       <= '0;
            pix_data   <= '0;
            pix_de     <= 1'b0;
            pix_vs     <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            line_err   <= 1'b0;
        end else begin
            s1_vs    <= cam_vsync;
            s1_hr    <= cam_href;
            s1_data  <= cam_data;
            s1_vs_d  <= s1_vs;
            s1_hr_d  <= s1_hr;
            vs_armed <= vs_armed | ~cam_vsync;

            byte_phase <= s1_hr ? ~byte_phase : 1'b0;
            if (s1_hr && !byte_phase)
                hi_byte <= s1_data;

            if (frame_start && frame_cnt != FC_MAX)
                frame_cnt <= frame_cnt + 1'b1;
            gate <= gate_nxt;

            if (line_end || frame_start)
                xcnt <= '0;
            else if (emit && xcnt != XY_MAX)
                xcnt <= xcnt + 11'd1;

            // frame start overrides the line-end increment when both occur
            if (frame_start)
                ycnt <= '0;
            else if (line_end && xcnt != 11'd0 && ycnt != XY_MAX)
                ycnt <= ycnt + 11'd1;

            if (!gate_nxt) begin
                pix_data <= '0;
                pix_de   <= 1'b0;
                pix_vs   <= 1'b0;
                pix_x    <= '0;
                pix_y    <= '0;
                line_err <= 1'b0;
            end else begin
                pix_vs   <= s1_vs;
                pix_de   <= emit;
                // a line finishing as the gate opens belongs to a closed frame
                line_err <= gate & line_end & bad_line;
                if (emit) begin
                    pix_data <= {hi_byte, s1_data};
                    pix_x    <= xcnt;
                    pix_y    <= ycnt;
                end
            end
        end
    end

endmodule
